mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Memory-side access controller for the Mini-SRC datapath. It sits directly upstream of the MDR and downstream of the control unit/MAR. It turns single-cycle read/write requests into timed accesses on a synchronous RAM with configurable latency. It produces Mdatain plus the MDR select (read) and load (enable) strobes, so the MDR captures memory data exactly once per read.

Parameters:
ADDR_WIDTH, 9, RAM word-address width (512 words).
DATA_WIDTH, 32, data word width.
READ_LATENCY, 1, cycles from ram_re-high cycle to ram_rdata valid; legal 1..15.
WRITE_CYCLES, 1, cycles ram_we is held high per write; legal 1..15.

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset (0 = reset)
read_req  in  1  one-cycle read request from control unit
write_req  in  1  one-cycle write request from control unit
MARout  in  ADDR_WIDTH  word address from MAR, sampled with the request
MDRout  in  DATA_WIDTH  write data from MDR, sampled with write_req
ram_rdata  in  DATA_WIDTH  RAM read data
ram_addr  out  ADDR_WIDTH  RAM address (registered)
ram_wdata  out  DATA_WIDTH  RAM write data (registered)
ram_re  out  1  RAM read strobe
ram_we  out  1  RAM write strobe
Mdatain  out  DATA_WIDTH  captured read data to MDR mux
mdr_read  out  1  MDR mux select (1 = memory path), one-cycle pulse
mdr_enable  out  1  MDR load enable, one-cycle pulse coincident with mdr_read
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
req_err  out  1  one-cycle pulse on dropped request

Behaviour:
- Reset (clear=0, async): state=IDLE; all outputs 0, including ram_addr, ram_wdata, Mdatain and the counter. A reset mid-access aborts it: ram_we/ram_re drop immediately, no done, no MDR load. Leaving reset is synchronous to the next rising clock edge.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_LOAD, WR_ACTIVE, WR_DONE.
- Request timing: requests are sampled only in IDLE. Call the sample edge cycle 0.
- IDLE + read_req:
  - latch MARout into ram_addr; go to RD_ISSUE.
- RD_ISSUE (cycle 1):
  - ram_re=1 for this cycle only.
  - counter loads READ_LATENCY-1.
  - If READ_LATENCY=1, go to RD_WAIT with counter=0; otherwise go to RD_WAIT.
- RD_WAIT:
  - counter decrements each cycle.
  - At counter=0 (cycle 1+READ_LATENCY), ram_rdata is captured into Mdatain at the end of the cycle; go to RD_LOAD.
- RD_LOAD (cycle 2+READ_LATENCY):
  - mdr_read=1, mdr_enable=1, done=1; return to IDLE.
  - Mdatain holds its value until the next read capture.
- IDLE + write_req (no read_req):
  - latch MARout into ram_addr and MDRout into ram_wdata; go to WR_ACTIVE.
- WR_ACTIVE:
  - ram_we=1 for exactly WRITE_CYCLES cycles (cycles 1..WRITE_CYCLES); address and data stable throughout.
  - Then go to WR_DONE.
- WR_DONE (cycle WRITE_CYCLES+1):
  - ram_we=0, done=1; return to IDLE.
- Simultaneous read_req and write_req in IDLE: the read wins, the write is dropped, and req_err pulses in cycle 1.
- Any read_req or write_req while busy=1 is ignored, and req_err pulses the following cycle. The state and latched address/data are unaffected.
- A request in the same cycle done is high is treated as "while busy": ignored, req_err. Back-to-back accesses require one IDLE cycle.
- ram_re and ram_we are never high in the same cycle. mdr_enable is never high outside RD_LOAD.
- Counter is 4 bits. It must not underflow; it reloads only in RD_ISSUE/IDLE→WR_ACTIVE.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum (6 states, 3-bit encoding);
  - the counter width constant (4);
  - the MAX_LATENCY constant (15).
- One sub-module, mem_latency_counter: a 4-bit loadable down-counter with async active-low clear, load, dec and a zero flag. It is shared by the read-wait and write-hold timing.
- Everything else stays in mem_access_ctrl.

Test Plan:
- Reset: clear=0 during an active write (WRITE_CYCLES=3, cycle 2) -> ram_we=0 immediately, busy=0, done never pulses, Mdatain=0.
- Read, READ_LATENCY=1: MARout=9'h05A, read_req cycle 0, RAM returns 32'hDEADBEEF -> ram_re high cycle 1 only, ram_addr=05A, Mdatain=DEADBEEF from cycle 3, mdr_read=mdr_enable=done=1 in cycle 3 only.
- Read, READ_LATENCY=4: same stimulus, data 32'h12345678 -> done/mdr_enable in cycle 6, busy high cycles 1..6.
- Write, WRITE_CYCLES=2: MARout=9'h1FF, MDRout=32'hCAFEF00D -> ram_we=1 cycles 1-2 with addr 1FF and data CAFEF00D stable, done in cycle 3, mdr_enable never high.
- Conflict: read_req=write_req=1 in IDLE -> read performed, req_err=1 in cycle 1, ram_we stays 0.
- Busy request: write_req pulsed in cycle 2 of a READ_LATENCY=3 read -> req_err in cycle 3, read completes normally in cycle 5, no write occurs.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the Mini-SRC memory access controller.
// The helper clamps a configured cycle count into the 4-bit counter range.
package mem_ctrl_pkg;

  localparam int CNT_WIDTH   = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ISSUE  = 3'd1,
    RD_WAIT   = 3'd2,
    RD_LOAD   = 3'd3,
    WR_ACTIVE = 3'd4,
    WR_DONE   = 3'd5
  } state_t;

  // Counter reload value for a phase lasting `cycles` cycles (clamped to 1..15).
  function automatic logic [CNT_WIDTH-1:0] cycles_to_count(input int cycles);
    int clamped;
    if (cycles < 1) begin
      clamped = 1;
    end else if (cycles > MAX_LATENCY) begin
      clamped = MAX_LATENCY;
    end else begin
      clamped = cycles;
    end
    return CNT_WIDTH'(clamped - 1);
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter timing both the read wait and the write hold.
// Saturates at zero so it can never wrap.
module mem_latency_counter
  import mem_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 dec,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= {CNT_WIDTH{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != {CNT_WIDTH{1'b0}})) begin
      count <= count - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns one-cycle read/write requests into timed synchronous-RAM accesses
// and produces the MDR data, select and load strobes for each read.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH-1:0] MARout,
  input  logic [DATA_WIDTH-1:0] MDRout,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  mdr_read,
  output logic                  mdr_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  req_err
);

  localparam logic [CNT_WIDTH-1:0] RD_COUNT = cycles_to_count(READ_LATENCY);
  localparam logic [CNT_WIDTH-1:0] WR_COUNT = cycles_to_count(WRITE_CYCLES);

  state_t               state;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [CNT_WIDTH-1:0] cnt_value;

  mem_latency_counter u_counter (
    .clock      (clock),
    .clear      (clear),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  // Counter control: reload when a write is accepted or a read is issued.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = WR_COUNT;
    case (state)
      IDLE: begin
        if (write_req && !read_req) begin
          cnt_load  = 1'b1;
          cnt_value = WR_COUNT;
        end else begin
          cnt_load  = 1'b0;
        end
      end
      RD_ISSUE: begin
        cnt_load  = 1'b1;
        cnt_value = RD_COUNT;
      end
      RD_WAIT, WR_ACTIVE: begin
        cnt_dec = !cnt_zero;
      end
      default: begin
        cnt_dec = 1'b0;
      end
    endcase
  end

  // Access FSM; every strobe is registered alongside the state it belongs to.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      ram_addr   <= {ADDR_WIDTH{1'b0}};
      ram_wdata  <= {DATA_WIDTH{1'b0}};
      Mdatain    <= {DATA_WIDTH{1'b0}};
      ram_re     <= 1'b0;
      ram_we     <= 1'b0;
      mdr_read   <= 1'b0;
      mdr_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      ram_re     <= 1'b0;
      ram_we     <= 1'b0;
      mdr_read   <= 1'b0;
      mdr_enable <= 1'b0;
      done       <= 1'b0;
      // Requests are dropped while busy, and a write loses to a simultaneous read.
      req_err    <= (state != IDLE) ? (read_req || write_req) : (read_req && write_req);
      case (state)
        IDLE: begin
          if (read_req) begin
            ram_addr <= MARout;
            ram_re   <= 1'b1;
            busy     <= 1'b1;
            state    <= RD_ISSUE;
          end else if (write_req) begin
            ram_addr  <= MARout;
            ram_wdata <= MDRout;
            ram_we    <= 1'b1;
            busy      <= 1'b1;
            state     <= WR_ACTIVE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RD_ISSUE: begin
          busy  <= 1'b1;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          busy <= 1'b1;
          if (cnt_zero) begin
            Mdatain    <= ram_rdata;
            mdr_read   <= 1'b1;
            mdr_enable <= 1'b1;
            done       <= 1'b1;
            state      <= RD_LOAD;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_LOAD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        WR_ACTIVE: begin
          busy <= 1'b1;
          if (cnt_zero) begin
            done  <= 1'b1;
            state <= WR_DONE;
          end else begin
            ram_we <= 1'b1;
            state  <= WR_ACTIVE;
          end
        end
        WR_DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
